// File: rtl/ic_scr_key_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ic_scr_key_ctrl_pkg
//   Shared types and widths for the icache scrambling-key controller.
//   Provides the default key/nonce widths used by the scrambled RAM banks and
//   the state encoding of the rekey sequencer.
// ---------------------------------------------------------------------------
package ic_scr_key_ctrl_pkg;

  // Default scrambling key and per-fetch nonce widths of the RAM banks.
  localparam int SCRAMBLE_KEY_W   = 128;
  localparam int SCRAMBLE_NONCE_W = 64;

  // Rekey sequencer states.
  typedef enum logic [1:0] {
    IC_KEY_IDLE,
    IC_KEY_REQ,
    IC_KEY_INVAL,
    IC_KEY_WAIT
  } ic_key_state_e;

endpackage

// File: rtl/ic_scr_key_ctrl.sv
// ---------------------------------------------------------------------------
// ic_scr_key_ctrl
//   Scrambling-key manager for the icache tag/data RAM banks. Fetches a fresh
//   key/nonce from the key source over a req/ack handshake, keeps a history of
//   the last NonceDepth nonces for the wide data banks, sequences an icache
//   invalidation after every rekey and tells the RAMs when the key is usable.
//
// Ports
//   clk_i          in   clock
//   rst_i          in   asynchronous reset, active-high
//   rekey_i        in   request a new key (level or pulse)
//   key_req_o      out  request to the key source, held until ack or abort
//   key_ack_i      in   key source ack; key_i/nonce_i valid with it
//   key_i          in   new key
//   nonce_i        in   new nonce
//   icache_inval_o out  one-cycle invalidate pulse to the icache
//   icache_busy_i  in   icache busy (invalidation in progress)
//   key_valid_o    out  key/nonce outputs stable and usable by the RAMs
//   key_o          out  current key for all banks
//   tag_nonce_o    out  newest nonce (tag banks)
//   data_nonce_o   out  nonce history {oldest..newest} (data banks)
//   busy_o         out  sequencer active or a rekey is pending
//   timeout_err_o  out  sticky flag: a key request timed out
// ---------------------------------------------------------------------------
module ic_scr_key_ctrl
  import ic_scr_key_ctrl_pkg::*;
#(
  parameter int                KeyW       = SCRAMBLE_KEY_W,
  parameter int                NonceW     = SCRAMBLE_NONCE_W,
  parameter int                NonceDepth = 2,
  parameter logic [KeyW-1:0]   ResetKey   = 128'h14e8cecae3040d5e12286bb3cc113298,
  parameter logic [NonceW-1:0] ResetNonce = 64'hf79780bc735f3843,
  parameter int                ReqTimeout = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rekey_i,
  output logic                         key_req_o,
  input  logic                         key_ack_i,
  input  logic [KeyW-1:0]              key_i,
  input  logic [NonceW-1:0]            nonce_i,
  output logic                         icache_inval_o,
  input  logic                         icache_busy_i,
  output logic                         key_valid_o,
  output logic [KeyW-1:0]              key_o,
  output logic [NonceW-1:0]            tag_nonce_o,
  output logic [NonceDepth*NonceW-1:0] data_nonce_o,
  output logic                         busy_o,
  output logic                         timeout_err_o
);

  localparam int CntW = $clog2(ReqTimeout);
  localparam logic [CntW-1:0] CntMax = CntW'(ReqTimeout - 1);

  ic_key_state_e state_q, state_d;
  logic          key_req_q, key_req_d;
  logic          inval_q, inval_d;
  logic          key_valid_q, key_valid_d;
  logic          pending_q, pending_d;
  logic          timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          load_key;

  logic [KeyW-1:0]                  key_q;
  // Entry 0 is the newest nonce; the highest index is the oldest.
  logic [NonceDepth-1:0][NonceW-1:0] hist_q;

  // Next-state and registered-output decode. A rekey request arriving while
  // the sequencer is busy is remembered in a single pending flag, so any
  // number of requests during one rekey collapse into one follow-up rekey.
  // The abort counter only advances while waiting for an ack and stops at
  // its terminal value, so it never wraps.
  always_comb begin
    state_d     = state_q;
    key_req_d   = key_req_q;
    inval_d     = 1'b0;
    key_valid_d = key_valid_q;
    pending_d   = pending_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    load_key    = 1'b0;

    if (rekey_i && (state_q != IC_KEY_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IC_KEY_IDLE: begin
        if (rekey_i || pending_q) begin
          state_d     = IC_KEY_REQ;
          pending_d   = 1'b0;
          key_valid_d = 1'b0;
          key_req_d   = 1'b1;
          cnt_d       = '0;
        end
      end
      IC_KEY_REQ: begin
        // An ack in the terminal cycle takes priority over the abort.
        if (key_ack_i) begin
          load_key  = 1'b1;
          key_req_d = 1'b0;
          inval_d   = 1'b1;
          state_d   = IC_KEY_INVAL;
        end else if (cnt_q == CntMax) begin
          timeout_d   = 1'b1;
          key_req_d   = 1'b0;
          key_valid_d = 1'b1;
          state_d     = IC_KEY_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      IC_KEY_INVAL: begin
        state_d = IC_KEY_WAIT;
      end
      IC_KEY_WAIT: begin
        if (!icache_busy_i) begin
          key_valid_d = 1'b1;
          state_d     = IC_KEY_IDLE;
        end
      end
      default: begin
        state_d = IC_KEY_IDLE;
      end
    endcase
  end

  // State and output registers. Key and nonce history only change on the
  // ack edge, which always falls inside the window where key_valid_o is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IC_KEY_IDLE;
      key_req_q   <= 1'b0;
      inval_q     <= 1'b0;
      key_valid_q <= 1'b1;
      pending_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      key_q       <= ResetKey;
      hist_q      <= {NonceDepth{ResetNonce}};
    end else begin
      state_q     <= state_d;
      key_req_q   <= key_req_d;
      inval_q     <= inval_d;
      key_valid_q <= key_valid_d;
      pending_q   <= pending_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      if (load_key) begin
        key_q <= key_i;
        for (int i = NonceDepth - 1; i > 0; i--) begin
          hist_q[i] <= hist_q[i-1];
        end
        hist_q[0] <= nonce_i;
      end
    end
  end

  assign key_req_o      = key_req_q;
  assign icache_inval_o = inval_q;
  assign key_valid_o    = key_valid_q;
  assign key_o          = key_q;
  assign tag_nonce_o    = hist_q[0];
  assign data_nonce_o   = hist_q;
  assign busy_o         = (state_q != IC_KEY_IDLE) || pending_q;
  assign timeout_err_o  = timeout_q;

  // Protocol invariants towards the key source, icache and RAM banks.
  ReqOnlyInReq: assert property (@(posedge clk_i) disable iff (rst_i)
    key_req_o |-> (state_q == IC_KEY_REQ));

  InvalSinglePulse: assert property (@(posedge clk_i) disable iff (rst_i)
    icache_inval_o |=> !icache_inval_o);

  KeyStableWhileValid: assert property (@(posedge clk_i) disable iff (rst_i)
    key_valid_o |=> $stable(key_o));

endmodule

// File: tb/tb_ic_scr_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ic_scr_key_ctrl
//   Self-checking bench for ic_scr_key_ctrl. A behavioural model keeps the
//   expected key and a queue of nonces; cycle-by-cycle expectations come from
//   the handshake latencies (request one cycle after rekey, invalidate one
//   cycle after ack, key valid once the icache is idle in the wait phase).
// ---------------------------------------------------------------------------
module tb_ic_scr_key_ctrl;

  localparam int            TO = 8;
  localparam logic [127:0]  RK = 128'h14e8cecae3040d5e12286bb3cc113298;
  localparam logic [63:0]   RN = 64'hf79780bc735f3843;

  logic         clk_i;
  logic         rst_i;
  logic         rekey_i;
  logic         key_req_o;
  logic         key_ack_i;
  logic [127:0] key_i;
  logic [63:0]  nonce_i;
  logic         icache_inval_o;
  logic         icache_busy_i;
  logic         key_valid_o;
  logic [127:0] key_o;
  logic [63:0]  tag_nonce_o;
  logic [127:0] data_nonce_o;
  logic         busy_o;
  logic         timeout_err_o;

  // Reference model state
  logic [127:0] m_key;
  logic [63:0]  m_hist[$];
  bit           m_err;

  int n_cmp;
  int n_fail;

  ic_scr_key_ctrl #(
    .ReqTimeout(TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rekey_i       (rekey_i),
    .key_req_o     (key_req_o),
    .key_ack_i     (key_ack_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .icache_inval_o(icache_inval_o),
    .icache_busy_i (icache_busy_i),
    .key_valid_o   (key_valid_o),
    .key_o         (key_o),
    .tag_nonce_o   (tag_nonce_o),
    .data_nonce_o  (data_nonce_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] exp_data_nonce();
    return {m_hist[0], m_hist[1]};
  endfunction

  function automatic logic [63:0] exp_tag_nonce();
    return m_hist[1];
  endfunction

  task automatic model_reset();
    m_key = RK;
    m_hist.delete();
    m_hist.push_back(RN);
    m_hist.push_back(RN);
    m_err = 1'b0;
  endtask

  // One rekey transaction starting in IDLE at cycle 0. The ack arrives at
  // cycle n_ack, the icache reports busy for busy_len cycles after the ack,
  // an extra rekey is optionally raised at cycle rekey_at (0 = none), and
  // from_pending means the transaction is started by a remembered request.
  // Returns positioned at the cycle where key_valid_o comes back.
  task automatic run_rekey_txn(input int n_ack, input int busy_len, input int rekey_at,
                               input bit from_pending, input logic [127:0] new_key,
                               input logic [63:0] new_nonce);
    int   vc;
    bit   pend;
    logic exp_req, exp_inval, exp_valid, exp_busy;
    vc   = (busy_len > 1) ? n_ack + busy_len + 2 : n_ack + 3;
    pend = 1'b0;
    for (int c = 0; c <= vc; c++) begin
      if (c == n_ack + 1) begin
        m_key = new_key;
        m_hist.push_back(new_nonce);
        void'(m_hist.pop_front());
      end
      if (rekey_at > 0 && c == rekey_at + 1) pend = 1'b1;
      exp_req   = (c >= 1) && (c <= n_ack);
      exp_inval = (c == n_ack + 1);
      exp_valid = (c == 0) || (c == vc);
      exp_busy  = (c == 0) ? from_pending : ((c < vc) ? 1'b1 : pend);

      n_cmp++;
      if (key_req_o !== exp_req) begin
        n_fail++; $display("[TB] FAIL txn_key_req c=%0d got %b exp %b", c, key_req_o, exp_req);
      end
      n_cmp++;
      if (icache_inval_o !== exp_inval) begin
        n_fail++; $display("[TB] FAIL txn_inval c=%0d got %b exp %b", c, icache_inval_o, exp_inval);
      end
      n_cmp++;
      if (key_valid_o !== exp_valid) begin
        n_fail++; $display("[TB] FAIL txn_key_valid c=%0d got %b exp %b", c, key_valid_o, exp_valid);
      end
      n_cmp++;
      if (busy_o !== exp_busy) begin
        n_fail++; $display("[TB] FAIL txn_busy c=%0d got %b exp %b", c, busy_o, exp_busy);
      end
      n_cmp++;
      if (key_o !== m_key) begin
        n_fail++; $display("[TB] FAIL txn_key c=%0d got %h exp %h", c, key_o, m_key);
      end
      n_cmp++;
      if (data_nonce_o !== exp_data_nonce()) begin
        n_fail++; $display("[TB] FAIL txn_data_nonce c=%0d got %h exp %h", c, data_nonce_o, exp_data_nonce());
      end
      n_cmp++;
      if (tag_nonce_o !== exp_tag_nonce()) begin
        n_fail++; $display("[TB] FAIL txn_tag_nonce c=%0d got %h exp %h", c, tag_nonce_o, exp_tag_nonce());
      end
      n_cmp++;
      if (timeout_err_o !== m_err) begin
        n_fail++; $display("[TB] FAIL txn_timeout_err c=%0d got %b exp %b", c, timeout_err_o, m_err);
      end

      if (c < vc) begin
        rekey_i = ((c == 0) && !from_pending) || (rekey_at > 0 && c == rekey_at);
        if (c == n_ack) begin
          key_ack_i = 1'b1;
          key_i     = new_key;
          nonce_i   = new_nonce;
        end else begin
          // Acks outside the request phase must be ignored.
          key_ack_i = ((c == 0) || (c > n_ack)) ? ($urandom_range(0, 3) == 0) : 1'b0;
          key_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
          nonce_i   = {$urandom(), $urandom()};
        end
        if (c <= n_ack) icache_busy_i = 1'($urandom_range(0, 1));
        else            icache_busy_i = (c <= n_ack + busy_len);
        step();
      end else begin
        rekey_i       = 1'b0;
        key_ack_i     = 1'b0;
        icache_busy_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rekey_i = 0; key_ack_i = 0; key_i = '0; nonce_i = '0; icache_busy_i = 0;
    rst_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (key_o !== RK) begin
      n_fail++; $display("[TB] FAIL reset_key got %h exp %h", key_o, RK);
    end
    n_cmp++;
    if (data_nonce_o !== {2{RN}}) begin
      n_fail++; $display("[TB] FAIL reset_data_nonce got %h exp %h", data_nonce_o, {2{RN}});
    end
    n_cmp++;
    if ({key_valid_o, key_req_o, icache_inval_o, busy_o, timeout_err_o} !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL reset_flags got %b exp %b",
                         {key_valid_o, key_req_o, icache_inval_o, busy_o, timeout_err_o}, 5'b10000);
    end
    step();
    step();
    rst_i = 1'b0;
    step();
    n_cmp++;
    if ({key_valid_o, key_req_o, busy_o} !== 3'b100 || key_o !== RK) begin
      n_fail++; $display("[TB] FAIL reset_release got v/r/b=%b key=%h exp 100 key=%h",
                         {key_valid_o, key_req_o, busy_o}, key_o, RK);
    end
  endtask

  task automatic test_rekey();
    run_rekey_txn(5, 0, 0, 1'b0, 128'h1, 64'hA);
    n_cmp++;
    if (data_nonce_o !== {RN, 64'hA}) begin
      n_fail++; $display("[TB] FAIL rekey_history got %h exp %h", data_nonce_o, {RN, 64'hA});
    end
    n_cmp++;
    if (key_o !== 128'h1 || key_valid_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rekey_final got key=%h v=%b b=%b exp key=1 v=1 b=0",
                         key_o, key_valid_o, busy_o);
    end
  endtask

  task automatic test_random_rekeys();
    bit pend_next;
    int n, b, vc, ra;
    pend_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n  = $urandom_range(1, TO);
      b  = $urandom_range(0, 5);
      vc = (b > 1) ? n + b + 2 : n + 3;
      ra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, vc - 1) : 0;
      run_rekey_txn(n, b, ra, pend_next,
                    {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
      pend_next = (ra > 0);
    end
    if (pend_next) begin
      run_rekey_txn($urandom_range(1, TO), 0, 0, 1'b1,
                    {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] n1, n2;
    int a;
    n1 = {$urandom(), $urandom()};
    n2 = {$urandom(), $urandom()};
    a  = $urandom_range(1, TO);
    // Rekey raised during the wait phase while the icache stays busy.
    run_rekey_txn(a, 10, a + 3, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, n1);
    run_rekey_txn($urandom_range(1, TO), 0, 0, 1'b1,
                  {$urandom(), $urandom(), $urandom(), $urandom()}, n2);
    n_cmp++;
    if (data_nonce_o !== {n1, n2}) begin
      n_fail++; $display("[TB] FAIL b2b_history got %h exp %h", data_nonce_o, {n1, n2});
    end
  endtask

  task automatic test_stray_ack();
    for (int c = 0; c < 4; c++) begin
      key_ack_i = 1'b1;
      key_i     = 128'hFF;
      nonce_i   = {$urandom(), $urandom()};
      step();
      n_cmp++;
      if (key_o !== m_key || data_nonce_o !== exp_data_nonce()) begin
        n_fail++; $display("[TB] FAIL stray_key c=%0d got %h/%h exp %h/%h",
                           c, key_o, data_nonce_o, m_key, exp_data_nonce());
      end
      n_cmp++;
      if ({icache_inval_o, key_req_o, busy_o, key_valid_o} !== 4'b0001) begin
        n_fail++; $display("[TB] FAIL stray_flags c=%0d got %b exp 0001",
                           c, {icache_inval_o, key_req_o, busy_o, key_valid_o});
      end
    end
    key_ack_i = 1'b0;
  endtask

  task automatic test_timeout();
    logic [127:0] k;
    logic exp_req, exp_valid, exp_busy, exp_err;
    // Ack in the last allowed cycle is accepted without an error.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_rekey_txn(TO, $urandom_range(0, 3), 0, 1'b0, k, {$urandom(), $urandom()});
    n_cmp++;
    if (timeout_err_o !== 1'b0 || key_o !== k) begin
      n_fail++; $display("[TB] FAIL late_ack got err=%b key=%h exp err=0 key=%h", timeout_err_o, key_o, k);
    end
    // No ack at all: abort after TO request cycles.
    for (int c = 0; c <= TO + 1; c++) begin
      exp_req   = (c >= 1) && (c <= TO);
      exp_valid = (c == 0) || (c == TO + 1);
      exp_busy  = (c >= 1) && (c <= TO);
      exp_err   = (c == TO + 1);
      n_cmp++;
      if ({key_req_o, key_valid_o, busy_o, timeout_err_o} !== {exp_req, exp_valid, exp_busy, exp_err}) begin
        n_fail++; $display("[TB] FAIL timeout_flags c=%0d got %b exp %b", c,
                           {key_req_o, key_valid_o, busy_o, timeout_err_o},
                           {exp_req, exp_valid, exp_busy, exp_err});
      end
      n_cmp++;
      if (key_o !== m_key || data_nonce_o !== exp_data_nonce()) begin
        n_fail++; $display("[TB] FAIL timeout_key c=%0d got %h exp %h", c, key_o, m_key);
      end
      if (c <= TO) begin
        rekey_i   = (c == 0);
        key_ack_i = 1'b0;
        key_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
      end
    end
    rekey_i = 1'b0;
    m_err   = 1'b1;
    // Error stays set across a following successful rekey.
    run_rekey_txn($urandom_range(1, TO), 1, 0, 1'b0,
                  {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
  endtask

  task automatic test_reset_mid_req();
    rekey_i = 1'b1;
    step();
    rekey_i = 1'b0;
    n_cmp++;
    if (key_req_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midreq_enter got %b exp 1", key_req_o);
    end
    step();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({key_req_o, key_valid_o, busy_o, timeout_err_o, icache_inval_o} !== 5'b01000) begin
      n_fail++; $display("[TB] FAIL midreq_flags got %b exp 01000",
                         {key_req_o, key_valid_o, busy_o, timeout_err_o, icache_inval_o});
    end
    n_cmp++;
    if (key_o !== RK || data_nonce_o !== {2{RN}} || tag_nonce_o !== RN) begin
      n_fail++; $display("[TB] FAIL midreq_key got %h/%h exp %h/%h", key_o, data_nonce_o, RK, {2{RN}});
    end
    step();
    rst_i = 1'b0;
    step();
    step();
    n_cmp++;
    if ({key_req_o, busy_o, key_valid_o} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL midreq_after got %b exp 001", {key_req_o, busy_o, key_valid_o});
    end
    run_rekey_txn($urandom_range(1, TO), 0, 0, 1'b0,
                  {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_rekey();
    test_random_rekeys();
    test_back_to_back();
    test_stray_ack();
    test_timeout();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
